hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_if.sv | 30 +++
 rtl/hazard_scoreboard.sv | 93 +++++++++
 tb/tb_hazard_scoreboard.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard bus: D-stage operand/destination info in, stall and forward selects out.
// The master is the decode stage; the slave is the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int NSRC  = 2,
  parameter int SEL_W = 2
);
  logic                    freeze;
  logic                    flush_e;
  logic                    valid_d;
  logic [4:0]              dst_d;
  logic [SEL_W-2:0]        rdy_d;
  logic [NSRC*5-1:0]       src_d;
  logic [NSRC-1:0]         use_d;
  logic                    mdu_start_d;
  logic                    hilo_use_d;
  logic                    stall_d;
  logic [NSRC*SEL_W-1:0]   fwd_sel;
  logic                    mdu_busy;
  logic [31:0]             stall_cnt;

  modport master (
    output freeze, flush_e, valid_d, dst_d, rdy_d, src_d, use_d, mdu_start_d, hilo_use_d,
    input  stall_d, fwd_sel, mdu_busy, stall_cnt
  );

  modport slave (
    input  freeze, flush_e, valid_d, dst_d, rdy_d, src_d, use_d, mdu_start_d, hilo_use_d,
    output stall_d, fwd_sel, mdu_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight write scoreboard giving per-source forward selects / decode stall; outputs combinational, state updates in 1 cycle.
// No backpressure of its own: freeze holds all state, stall_d holds F/D. Optional stall counter under HAZARD_PERF_EN.
module hazard_scoreboard #(
  parameter int STAGES  = 3,
  parameter int NSRC    = 2,
  parameter int MDU_LAT = 5,
  parameter int SEL_W   = $clog2(STAGES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
);

  localparam int CNT_W = $clog2(MDU_LAT + 1);

  typedef struct packed {
    logic             v;
    logic [4:0]       dst;
    logic [SEL_W-2:0] rdy;
  } entry_t;

  entry_t            sb [STAGES];
  logic [CNT_W-1:0]  mdu_cnt;

  logic [NSRC-1:0]   hit;
  logic [SEL_W-1:0]  hit_slot [NSRC];
  logic [NSRC-1:0]   src_stall;
  logic [NSRC*SEL_W-1:0] fwd;
  logic              stall;
  logic              busy;

  always_comb begin
    hit       = '0;
    src_stall = '0;
    fwd       = '0;
    for (int j = 0; j < NSRC; j++) begin
      hit_slot[j] = '0;
      // Scan oldest to youngest so the youngest match (slot 0 side) is the final winner.
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (sb[i].v && (sb[i].dst == bus.src_d[j*5 +: 5])) begin
          hit[j]      = 1'b1;
          hit_slot[j] = SEL_W'(i);
        end
      end
      if (bus.use_d[j] && (bus.src_d[j*5 +: 5] != 5'd0) && hit[j]) begin
        if (hit_slot[j] >= {1'b0, sb[hit_slot[j]].rdy})
          fwd[j*SEL_W +: SEL_W] = hit_slot[j] + SEL_W'(1);
        else
          src_stall[j] = 1'b1;
      end
    end
  end

  assign busy  = (mdu_cnt != '0);
  assign stall = bus.valid_d &&
                 ((|src_stall) || (busy && (bus.hilo_use_d || bus.mdu_start_d)));

  assign bus.stall_d  = stall;
  assign bus.fwd_sel  = fwd;
  assign bus.mdu_busy = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sb[i] <= '0;
      mdu_cnt <= '0;
    end else if (!bus.freeze) begin
      for (int i = 1; i < STAGES; i++) sb[i] <= sb[i-1];
      sb[0].v   <= bus.valid_d && !stall && !bus.flush_e && (bus.dst_d != 5'd0);
      sb[0].dst <= bus.dst_d;
      sb[0].rdy <= bus.rdy_d;
      if (bus.valid_d && bus.mdu_start_d && !stall)
        mdu_cnt <= CNT_W'(MDU_LAT);
      else if (mdu_cnt != '0)
        mdu_cnt <= mdu_cnt - CNT_W'(1);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (!bus.freeze && stall)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use, youngest-wins, MDU busy, freeze/flush, async reset.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NSRC(2), .SEL_W(2)) bus ();

  hazard_scoreboard #(.STAGES(3), .NSRC(2), .MDU_LAT(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef HAZARD_PERF_EN
  localparam logic [31:0] MDU_STALLS = 32'd5;
`else
  localparam logic [31:0] MDU_STALLS = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] dst, input logic rdy,
                       input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] use_,
                       input logic mdu, input logic hilo);
    bus.valid_d     = v;
    bus.dst_d       = dst;
    bus.rdy_d       = rdy;
    bus.src_d       = {s1, s0};
    bus.use_d       = use_;
    bus.mdu_start_d = mdu;
    bus.hilo_use_d  = hilo;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic st, input logic [3:0] fs);
    chk({tag, "_stall"}, 32'(bus.stall_d), 32'(st));
    chk({tag, "_fwd"},   32'(bus.fwd_sel), 32'(fs));
  endtask

  initial begin
    bus.freeze  = 1'b0;
    bus.flush_e = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);

    // Reset state, including with busy-looking D inputs
    chk_out("rst_idle", 1'b0, 4'h0);
    chk("rst_busy", 32'(bus.mdu_busy), 32'd0);
    chk("rst_cnt", bus.stall_cnt, 32'd0);
    drive(1'b1, 5'd8, 1'b1, 5'd8, 5'd8, 2'b11, 1'b1, 1'b1);
    chk_out("rst_any", 1'b0, 4'h0);
    tick();
    tick();
    #3 rst_n = 1'b1;

    // Back-to-back ALU dependency
    drive(1'b1, 5'd8, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 5'd8, 2'b01, 1'b0, 1'b0);
    chk_out("alu_e", 1'b0, 4'h1);
    tick();
    chk_out("alu_m", 1'b0, 4'h2);
    tick();

    // Load-use: one stall, then forward from slot 1
    drive(1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd9, 5'd0, 2'b10, 1'b0, 1'b0);
    chk_out("ld_use_stall", 1'b1, 4'h0);
    tick();
    chk_out("ld_use_fwd", 1'b0, 4'h8);
    tick();

    // Youngest wins (forwarding case) and $0 source
    drive(1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 5'd5, 2'b11, 1'b0, 1'b0);
    chk_out("young_fwd", 1'b0, 4'h1);
    tick();

    // Youngest wins even when it stalls and an older match could forward
    drive(1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 5'd5, 2'b01, 1'b0, 1'b0);
    chk_out("young_stall", 1'b1, 4'h0);
    tick();
    chk_out("young_after", 1'b0, 4'h2);
    tick();

    // Freeze holding a stalled load-use pair
    drive(1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd9, 5'd0, 2'b10, 1'b0, 1'b0);
    bus.freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk_out("frz_hold", 1'b1, 4'h0);
      tick();
    end
    bus.freeze = 1'b0;
    #1;
    chk_out("frz_rel", 1'b1, 4'h0);
    tick();
    chk_out("frz_fwd", 1'b0, 4'h8);
    tick();

    // Flushed write to $7 must not be tracked
    drive(1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    bus.flush_e = 1'b1;
    tick();
    bus.flush_e = 1'b0;
    drive(1'b1, 5'd0, 1'b0, 5'd0, 5'd7, 2'b01, 1'b0, 1'b0);
    chk_out("flush", 1'b0, 4'h0);
    tick();

    // Asynchronous reset between edges
    drive(1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd9, 5'd0, 2'b10, 1'b0, 1'b1);
    chk_out("pre_rst", 1'b1, 4'h0);
    chk("pre_rst_busy", 32'(bus.mdu_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_out("arst", 1'b0, 4'h0);
    chk("arst_busy", 32'(bus.mdu_busy), 32'd0);
    chk("arst_cnt", bus.stall_cnt, 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // MDU busy: hilo reader right after mdu_start stalls MDU_LAT cycles
    drive(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
    chk_out("mdu_start", 1'b0, 4'h0);
    chk("mdu_idle", 32'(bus.mdu_busy), 32'd0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("mdu_stall", 32'(bus.stall_d), 32'd1);
      chk("mdu_busy", 32'(bus.mdu_busy), 32'd1);
      tick();
    end
    chk("mdu_done_stall", 32'(bus.stall_d), 32'd0);
    chk("mdu_done_busy", 32'(bus.mdu_busy), 32'd0);
    chk("mdu_stall_cnt", bus.stall_cnt, MDU_STALLS);

    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
